// File: rtl/filter_seq_pkg.sv
// Shared definitions for the filter sequencer stage interface.
// Contents: stage count and index width, the final-stage index, named stage
// constants S0..S8, monitor state encodings, and the successor-stage helper.
package filter_seq_pkg;

    localparam int unsigned NUM_STAGES = 9;
    localparam int unsigned STAGE_W    = 4;

    typedef logic [STAGE_W-1:0] stage_t;

    localparam stage_t FINAL_STAGE = stage_t'(0);
    localparam stage_t LAST_STAGE  = stage_t'(NUM_STAGES - 1);

    localparam stage_t S0 = stage_t'(0);
    localparam stage_t S1 = stage_t'(1);
    localparam stage_t S2 = stage_t'(2);
    localparam stage_t S3 = stage_t'(3);
    localparam stage_t S4 = stage_t'(4);
    localparam stage_t S5 = stage_t'(5);
    localparam stage_t S6 = stage_t'(6);
    localparam stage_t S7 = stage_t'(7);
    localparam stage_t S8 = stage_t'(8);

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_LOCKED  = 2'd1,
        ST_ERROR   = 2'd2
    } mon_state_e;

    // Stream order is 1,2,..,LAST_STAGE,0,1,..; 0 is the final stage of a pass.
    function automatic stage_t next_stage(input stage_t s);
        return (s == LAST_STAGE) ? FINAL_STAGE : stage_t'(s + stage_t'(1));
    endfunction

endpackage

// File: rtl/filter_stage_decoder.sv
// Registered binary-to-one-hot stage decoder.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   en     in   decode stage this cycle; otherwise output goes to zero
//   clr    in   forces output to zero (takes priority over en)
//   stage  in   binary stage index
//   onehot out  registered one-hot of stage, all-zero when not enabled
module filter_stage_decoder
    import filter_seq_pkg::*;
#(
    parameter int unsigned NUM_ST = NUM_STAGES,
    parameter int unsigned IDX_W  = STAGE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [IDX_W-1:0]  stage,
    output logic [NUM_ST-1:0] onehot
);

    logic [NUM_ST-1:0] onehot_d;

    always_comb begin
        onehot_d = '0;
        for (int i = 0; i < NUM_ST; i++) begin
            onehot_d[i] = en && !clr && (stage == IDX_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            onehot <= '0;
        end else begin
            onehot <= onehot_d;
        end
    end

endmodule

// File: rtl/filter_stage_monitor.sv
// Receive-side monitor for the filter-sequencer stage stream.
// Locks onto the cyclic stream 1..NUM_STAGES-1,0, drives one-hot per-stage filter
// enables, counts completed passes and flags sequence violations (sticky).
// Stage count and index width come from filter_seq_pkg.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset, overrides all inputs
//   stage_in   in   stage index from sequencer
//   final_in   in   final-stage flag, must be high exactly when stage_in == 0
//   err_clr    in   leaves ERROR back to ACQUIRE (ignored in other states)
//   filt_en    out  one-hot enable of the accepted stage, one cycle after sampling
//   pass_done  out  one-cycle pulse when stage 0 is accepted
//   pass_count out  completed passes since reset, wrapping
//   locked     out  high while LOCKED
//   seq_err    out  sticky violation flag
module filter_stage_monitor
    import filter_seq_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STAGE_W-1:0]    stage_in,
    input  logic                  final_in,
    input  logic                  err_clr,
    output logic [NUM_STAGES-1:0] filt_en,
    output logic                  pass_done,
    output logic [CNT_W-1:0]      pass_count,
    output logic                  locked,
    output logic                  seq_err
);

    mon_state_e         state_q;
    stage_t             expected_q;
    logic [CNT_W-1:0]   pass_count_q;
    logic               pass_done_q;
    logic               locked_q;
    logic               seq_err_q;

    logic legal;
    logic accept;

    always_comb begin
        legal  = (stage_in <= LAST_STAGE) && (final_in == (stage_in == FINAL_STAGE));
        accept = (state_q == ST_LOCKED) && legal && (stage_in == expected_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_ACQUIRE;
            expected_q   <= S1;
            pass_count_q <= '0;
            pass_done_q  <= 1'b0;
            locked_q     <= 1'b0;
            seq_err_q    <= 1'b0;
        end else begin
            pass_done_q <= 1'b0;
            case (state_q)
                ST_ACQUIRE: begin
                    // Only a clean final-stage sample locks; anything else is ignored.
                    if (legal && stage_in == FINAL_STAGE) begin
                        state_q    <= ST_LOCKED;
                        expected_q <= S1;
                        locked_q   <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    // err_clr is deliberately ignored here so a violation always wins.
                    if (accept) begin
                        expected_q <= next_stage(stage_in);
                        if (stage_in == FINAL_STAGE) begin
                            pass_done_q  <= 1'b1;
                            pass_count_q <= pass_count_q + 1'b1;
                        end
                    end else begin
                        state_q   <= ST_ERROR;
                        locked_q  <= 1'b0;
                        seq_err_q <= 1'b1;
                    end
                end
                ST_ERROR: begin
                    if (err_clr) begin
                        state_q   <= ST_ACQUIRE;
                        seq_err_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_ACQUIRE;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    // Enable is registered inside the decoder so it lines up with the other outputs.
    filter_stage_decoder #(
        .NUM_ST (NUM_STAGES),
        .IDX_W  (STAGE_W)
    ) u_decoder (
        .clk    (clk),
        .rst    (rst),
        .en     (accept),
        .clr    (state_q != ST_LOCKED),
        .stage  (stage_in),
        .onehot (filt_en)
    );

    assign pass_done  = pass_done_q;
    assign pass_count = pass_count_q;
    assign locked     = locked_q;
    assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_filter_stage_monitor.sv
module tb_filter_stage_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  stage_in;
    logic        final_in;
    logic        err_clr;
    logic [8:0]  filt_en;
    logic        pass_done;
    logic [15:0] pass_count;
    logic        locked;
    logic        seq_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  stage;
        logic        fin;
        logic        clr;
        logic [8:0]  filt;
        logic        pd;
        logic [15:0] cnt;
        logic        lk;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    filter_stage_monitor #(
        .CNT_W (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stage_in   (stage_in),
        .final_in   (final_in),
        .err_clr    (err_clr),
        .filt_en    (filt_en),
        .pass_done  (pass_done),
        .pass_count (pass_count),
        .locked     (locked),
        .seq_err    (seq_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Apply one sample, let it be clocked in, then sample outputs 1 time unit later.
    task automatic drive(input logic r, input logic [3:0] s, input logic f, input logic c);
        rst      = r;
        stage_in = s;
        final_in = f;
        err_clr  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic [3:0] s, input logic f, input logic c,
                       input logic [8:0] filt, input logic pd, input logic [15:0] cnt,
                       input logic lk, input logic err);
        vec_t v;
        v.rst = r; v.stage = s; v.fin = f; v.clr = c;
        v.filt = filt; v.pd = pd; v.cnt = cnt; v.lk = lk; v.err = err;
        vecs.push_back(v);
    endtask

    task automatic run_passes(input int n);
        for (int p = 0; p < n; p++) begin
            for (int k = 1; k <= 9; k++) begin
                drive(1'b0, (k == 9) ? 4'd0 : 4'(k), k == 9, 1'b0);
            end
        end
    endtask

    initial begin
        logic [8:0] one;
        int         pulses;
        int         consec;
        logic       prev_pd;

        rst = 1'b1; stage_in = '0; final_in = 1'b0; err_clr = 1'b0;
        one = 9'd1;

        // reset with arbitrary inputs
        add(1, 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 0, 0, 0, 0, 0);
        add(1, 0, 1, 0,  0, 0, 0, 0, 0);
        // acquire ignores junk
        add(0, 3, 0, 0,  0, 0, 0, 0, 0);
        add(0, 0, 0, 0,  0, 0, 0, 0, 0);
        // lock without enable, then a full pass
        add(0, 0, 1, 0,  0, 0, 0, 1, 0);
        for (int s = 1; s <= 8; s++) add(0, 4'(s), 0, 0, one << s, 0, 0, 1, 0);
        add(0, 0, 1, 0,  9'h001, 1, 1, 1, 0);
        add(0, 1, 0, 0,  9'h002, 0, 1, 1, 0);
        add(0, 2, 0, 0,  9'h004, 0, 1, 1, 0);
        add(0, 3, 0, 0,  9'h008, 0, 1, 1, 0);
        // out of order 3 -> 5
        add(0, 5, 0, 0,  0, 0, 1, 0, 1);
        add(0, 6, 0, 0,  0, 0, 1, 0, 1);
        add(0, 0, 1, 0,  0, 0, 1, 0, 1);
        add(0, 9, 0, 1,  0, 0, 1, 0, 0);
        add(0, 0, 1, 0,  0, 0, 1, 1, 0);
        add(0, 1, 0, 0,  9'h002, 0, 1, 1, 0);
        add(0, 2, 0, 0,  9'h004, 0, 1, 1, 0);
        add(0, 3, 0, 0,  9'h008, 0, 1, 1, 0);
        // right index, wrong final flag
        add(0, 4, 1, 0,  0, 0, 1, 0, 1);
        add(0, 0, 0, 1,  0, 0, 1, 0, 0);
        add(0, 0, 1, 0,  0, 0, 1, 1, 0);
        // err_clr in LOCKED has no effect; coincident with violation -> ERROR
        add(0, 1, 0, 1,  9'h002, 0, 1, 1, 0);
        add(0, 2, 1, 1,  0, 0, 1, 0, 1);
        add(0, 2, 0, 0,  0, 0, 1, 0, 1);
        add(0, 0, 0, 1,  0, 0, 1, 0, 0);
        add(0, 12, 0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 1, 0,  0, 0, 1, 1, 0);
        // out-of-range index while locked
        add(0, 15, 0, 0, 0, 0, 1, 0, 1);
        add(0, 0, 1, 1,  0, 0, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].stage, vecs[i].fin, vecs[i].clr);
            check($sformatf("vec%0d.filt_en", i),    32'(filt_en),    32'(vecs[i].filt));
            check($sformatf("vec%0d.pass_done", i),  32'(pass_done),  32'(vecs[i].pd));
            check($sformatf("vec%0d.pass_count", i), 32'(pass_count), 32'(vecs[i].cnt));
            check($sformatf("vec%0d.locked", i),     32'(locked),     32'(vecs[i].lk));
            check($sformatf("vec%0d.seq_err", i),    32'(seq_err),    32'(vecs[i].err));
        end

        // long run: 1000 clean passes from reset
        drive(1'b1, 4'd0, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 1'b1, 1'b0);
        pulses = 0; consec = 0; prev_pd = 1'b0;
        for (int p = 0; p < 1000; p++) begin
            for (int k = 1; k <= 9; k++) begin
                drive(1'b0, (k == 9) ? 4'd0 : 4'(k), k == 9, 1'b0);
                if (pass_done) pulses++;
                if (pass_done && prev_pd) consec++;
                prev_pd = pass_done;
            end
        end
        check("long.pass_count", 32'(pass_count), 32'd1000);
        check("long.pulses",     32'(pulses),     32'd1000);
        check("long.consec_pd",  32'(consec),     32'd0);
        check("long.seq_err",    32'(seq_err),    32'd0);
        check("long.locked",     32'(locked),     32'd1);

        // reset at stage 5 of pass 3
        drive(1'b1, 4'd0, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 1'b1, 1'b0);
        run_passes(2);
        check("mid.pre_count", 32'(pass_count), 32'd2);
        for (int s = 1; s <= 4; s++) drive(1'b0, 4'(s), 1'b0, 1'b0);
        check("mid.pre_filt", 32'(filt_en), 32'h010);
        drive(1'b1, 4'd5, 1'b0, 1'b0);
        check("mid.filt_en",    32'(filt_en),    32'd0);
        check("mid.pass_done",  32'(pass_done),  32'd0);
        check("mid.pass_count", 32'(pass_count), 32'd0);
        check("mid.locked",     32'(locked),     32'd0);
        check("mid.seq_err",    32'(seq_err),    32'd0);
        drive(1'b0, 4'd6, 1'b0, 1'b0);
        check("mid.no_lock_6",  32'(locked),     32'd0);
        check("mid.no_en_6",    32'(filt_en),    32'd0);
        drive(1'b0, 4'd0, 1'b1, 1'b0);
        check("mid.relock",     32'(locked),     32'd1);
        check("mid.relock_en",  32'(filt_en),    32'd0);
        check("mid.relock_pd",  32'(pass_done),  32'd0);
        drive(1'b0, 4'd1, 1'b0, 1'b0);
        check("mid.stage1_en",  32'(filt_en),    32'h002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
